cl_sde_argmax_pack: RTL
=======================

# cl_sde_argmax_pack

Downstream stage of the SDE VGG inference path. Consumes one vector of class scores per image from the VGG wrapper, finds the winning class with a sequential signed argmax, and packs one 32-bit result record per image into 512-bit AXI-stream beats. Its output feeds the output `fifo_axi_512`. Beats are sent when full, on an explicit flush, or on an idle timeout.

## Interface
- `NUM_CLASSES`, 10: scores per vector (2..16).
- `SCORE_W`, 16: signed score width.
- `RES_PER_BEAT`, 16: 32-bit records per 512-bit beat.
- `FLUSH_CYCLES`, 1024: idle cycles before a partial beat is sent (timeout build only).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `score_valid`  in  1  score vector valid.
- `score_ready`  out  1  vector accepted when high with `score_valid`.
- `score_data`  in  NUM_CLASSES*SCORE_W  class i at bits [i*SCORE_W +: SCORE_W], two's complement.
- `flush`  in  1  single-cycle request to send the partial beat.
- `ots_valid`  out  1  beat valid.
- `ots_ready`  in  1  downstream ready.
- `ots_data`  out  512  record k at bits [k*32 +: 32]; unused slots zero.
- `ots_keep`  out  64  4 bits set per filled slot, LSB first.
- `ots_last`  out  1  constant 1 while `ots_valid` is high.
- `img_count`  out  32  images accepted since reset; wraps.

## Operation
- Record layout:
  - [31:16] winning score.
  - [15:4] image sequence number, mod 4096.
  - [3:0] class index.
- FSM states: IDLE, SCAN, PACK, SEND.
- IDLE
  - `score_ready`=1.
  - On accept: latch the vector, set best = class 0, idx = 1, `img_count`++, go to SCAN.
- SCAN
  - One compare per cycle: if score[idx] > best (signed, strict), best and best_idx take class idx.
  - Ties keep the lowest index.
  - After idx = NUM_CLASSES-1, go to PACK.
- PACK
  - Write the record into slot `fill`; `fill`++.
  - Go to SEND if `fill` reaches RES_PER_BEAT or a flush is pending. Otherwise go to IDLE.
- SEND
  - `ots_valid`=1, with data and keep stable until `ots_ready`.
  - On handshake: clear all slots to zero, `fill`=0, clear the pending flush, go to IDLE.
- Flush handling:
  - `flush` is latched as pending in any state.
  - Acted on in IDLE (go to SEND) or in PACK.
  - If `fill`=0 in IDLE, the pending flag is cleared and no empty beat is sent.
- Reset (mid-operation included):
  - Outputs: `score_ready`=0, `ots_valid`=0, `ots_data`=0, `ots_keep`=0, `ots_last`=0, `img_count`=0.
  - Any partial beat is discarded.
  - State is IDLE after the first clock edge with `rst_n` high; `score_ready` rises there.

## Timing
- Vector accepted at edge T. Compares occur in cycles T+1 .. T+NUM_CLASSES-1. PACK is at cycle T+NUM_CLASSES.
- `score_ready` is low for NUM_CLASSES cycles after an accept. Throughput is one vector per NUM_CLASSES+1 cycles (11 at defaults).
- Full beat: `ots_valid` rises the cycle after PACK of the RES_PER_BEAT-th record.
- SEND with `ots_ready` high completes in 1 cycle; IDLE (`score_ready`=1) follows on the next cycle.
- `flush` in IDLE with `fill`>0: `ots_valid` rises 1 cycle later.
- Backpressure: SEND is held indefinitely; `score_ready`=0 throughout.

## Configuration
- `CL_SDE_ARGMAX_TIMEOUT_EN` defined:
  - An idle counter increments each IDLE cycle with `fill`>0 and no accept. It clears on accept or on leaving IDLE.
  - When it reaches FLUSH_CYCLES, the FSM behaves as for `flush`.
- Undefined: no counter; partial beats leave only via `flush`.

## Structure
- Shared package `cl_sde_pkg`:
  - `sde_result_t` packed record typedef.
  - FSM state enum.
  - `SDE_RES_W`=32 and `SDE_BEAT_W`=512 constants.
- One sub-module `cl_sde_argmax_scan`: latched vector, index counter, compare; pulses `done` with best score and index.
- Packing, flush and timeout logic, FSM, and AXI output stay in `cl_sde_argmax_pack`.

## Test plan
- Vector scores {5,-3,100,7,100,0,0,0,0,-32768}, `ots_ready`=1, then `flush` → after 11 cycles record 0 = score 100, seq 0, idx 2 (tie keeps lower index); on flush, `ots_keep`=64'hF, `ots_last`=1.
- All scores -1 (16'hFFFF) → idx 0, score 16'hFFFF (signed compare).
- 16 back-to-back vectors with the winner at idx = k mod 10 → one beat, `ots_keep` all ones, seq 0..15 in slots 0..15; `score_ready` low for 10 of every 11 cycles.
- 17 vectors with `ots_ready` held low for 50 cycles → beat 1 stable and `score_ready`=0 for the whole stall; the 17th record lands in slot 0 of beat 2 with seq 16.
- Timeout build, 3 vectors then idle → partial beat `ots_keep`=64'hFFF after 1024 idle cycles; the non-timeout build sends nothing until `flush`.
- Assert `rst_n` low during SCAN and during SEND → outputs 0 immediately; after release no stale beat appears and `img_count`=0.

Source files
------------

// File: rtl/cl_sde_pkg.sv
// ---------------------------------------------------------------------------
// cl_sde_pkg
//   Shared types and constants for the SDE argmax/pack output stage.
//   - sde_result_t : one 32-bit per-image result record
//                    {score[15:0], seq[11:0], class idx[3:0]}
//   - sde_state_t  : pack-stage FSM states
//   - SDE_RES_W / SDE_BEAT_W : record and AXI-stream beat widths
// ---------------------------------------------------------------------------
package cl_sde_pkg;

  localparam int SDE_RES_W  = 32;
  localparam int SDE_BEAT_W = 512;

  typedef struct packed {
    logic [15:0] score;  // winning score (two's complement)
    logic [11:0] seq;    // image sequence number, mod 4096
    logic [3:0]  idx;    // winning class index
  } sde_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PACK,
    ST_SEND
  } sde_state_t;

endpackage

// File: rtl/cl_sde_argmax_scan.sv
// ---------------------------------------------------------------------------
// cl_sde_argmax_scan
//   Sequential signed argmax over one latched score vector, one compare per
//   cycle. Ties keep the lowest class index (strict greater-than).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     start       : latch vec and begin a scan (class 0 is the initial best)
//     vec         : NUM_CLASSES scores, class i at [i*SCORE_W +: SCORE_W]
//     last        : high during the cycle of the final compare
//     done        : one-cycle pulse after the final compare; best_* final
//     best_score  : current best score
//     best_idx    : current best class index
// ---------------------------------------------------------------------------
module cl_sde_argmax_scan #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_CLASSES*SCORE_W-1:0] vec,
  output logic                           last,
  output logic                           done,
  output logic [SCORE_W-1:0]             best_score,
  output logic [3:0]                     best_idx
);

  logic [NUM_CLASSES*SCORE_W-1:0] vec_reg;
  logic [3:0]                     idx_reg;
  logic                           busy_reg;
  logic                           done_reg;
  logic [SCORE_W-1:0]             best_score_reg;
  logic [3:0]                     best_idx_reg;
  logic [SCORE_W-1:0]             cur_score;

  assign cur_score  = vec_reg[idx_reg*SCORE_W +: SCORE_W];
  assign last       = busy_reg && (idx_reg == 4'(NUM_CLASSES - 1));
  assign done       = done_reg;
  assign best_score = best_score_reg;
  assign best_idx   = best_idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_reg        <= '0;
      idx_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      best_score_reg <= '0;
      best_idx_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        vec_reg        <= vec;
        best_score_reg <= vec[SCORE_W-1:0];
        best_idx_reg   <= 4'd0;
        idx_reg        <= 4'd1;
        busy_reg       <= 1'b1;
      end else if (busy_reg) begin
        // Strict compare: an equal later score never displaces an earlier one.
        if ($signed(cur_score) > $signed(best_score_reg)) begin
          best_score_reg <= cur_score;
          best_idx_reg   <= idx_reg;
        end
        if (last) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cl_sde_argmax_pack.sv
// ---------------------------------------------------------------------------
// cl_sde_argmax_pack
//   Accepts one class-score vector per image, finds the winning class with
//   cl_sde_argmax_scan, and packs one 32-bit record per image into 512-bit
//   AXI-stream beats. A beat is sent when full, on flush, or (optionally) on
//   an idle timeout.
//   Optional feature: define CL_SDE_ARGMAX_TIMEOUT_EN to send a partial beat
//   after FLUSH_CYCLES idle cycles; otherwise only flush drains partial beats.
//   Ports:
//     clk, rst_n               : clock, asynchronous active-low reset
//     score_valid/score_ready  : score vector handshake
//     score_data               : class i at [i*SCORE_W +: SCORE_W]
//     flush                    : single-cycle request to send the partial beat
//     ots_valid/ots_ready      : beat handshake
//     ots_data                 : record k at [k*32 +: 32], unused slots zero
//     ots_keep                 : 4'hF per filled slot, LSB first
//     ots_last                 : high with every beat
//     img_count                : images accepted since reset (wraps)
// ---------------------------------------------------------------------------
module cl_sde_argmax_pack
  import cl_sde_pkg::*;
#(
  parameter int NUM_CLASSES  = 10,
  parameter int SCORE_W      = 16,
  parameter int RES_PER_BEAT = 16,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           score_valid,
  output logic                           score_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] score_data,
  input  logic                           flush,
  output logic                           ots_valid,
  input  logic                           ots_ready,
  output logic [SDE_BEAT_W-1:0]          ots_data,
  output logic [63:0]                    ots_keep,
  output logic                           ots_last,
  output logic [31:0]                    img_count
);

  localparam int FILL_W   = $clog2(RES_PER_BEAT + 1);
  localparam int MAX_SLOT = SDE_BEAT_W / SDE_RES_W;

  if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || RES_PER_BEAT < 1 ||
      RES_PER_BEAT > MAX_SLOT || FLUSH_CYCLES < 1) begin : g_bad_param
    $error("cl_sde_argmax_pack: parameter out of range");
  end

  sde_state_t        state_reg, state_next;
  logic              live_reg;       // low until the first edge after reset
  logic [FILL_W-1:0] fill_reg;
  logic              flush_pend_reg;
  logic [11:0]       seq_reg;
  logic [31:0]       img_count_reg;

  logic              accept, flush_req, timeout_hit, pend_clr, beat_done, pack_we;
  logic              scan_last, scan_done;
  logic [SCORE_W-1:0] scan_best_score;
  logic [3:0]        scan_best_idx;
  sde_result_t       rec;

  cl_sde_argmax_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .vec        (score_data),
    .last       (scan_last),
    .done       (scan_done),
    .best_score (scan_best_score),
    .best_idx   (scan_best_idx)
  );

  assign score_ready = live_reg && (state_reg == ST_IDLE);
  assign accept      = score_valid && score_ready;
  assign ots_valid   = (state_reg == ST_SEND);
  assign ots_last    = ots_valid;
  assign img_count   = img_count_reg;
  // The raw flush pulse is honoured in the same cycle so an idle flush
  // raises ots_valid one cycle later; the latched copy covers busy states.
  assign flush_req   = flush_pend_reg || flush || timeout_hit;
  assign pack_we     = (state_reg == ST_PACK) && scan_done;

  always_comb begin
    rec       = '0;
    rec.score = 16'($signed(scan_best_score));
    rec.seq   = seq_reg;
    rec.idx   = scan_best_idx;
  end

  always_comb begin
    state_next = state_reg;
    pend_clr   = 1'b0;
    beat_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SCAN;
        end else if (flush_req) begin
          if (fill_reg != '0) state_next = ST_SEND;
          else                pend_clr   = 1'b1;  // nothing to send
        end
      end
      ST_SCAN: if (scan_last) state_next = ST_PACK;
      ST_PACK: begin
        // fill_reg still holds the pre-increment count here.
        if (fill_reg == FILL_W'(RES_PER_BEAT - 1) || flush_req) state_next = ST_SEND;
        else                                                     state_next = ST_IDLE;
      end
      ST_SEND: begin
        if (ots_ready) begin
          beat_done  = 1'b1;
          pend_clr   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      live_reg       <= 1'b0;
      fill_reg       <= '0;
      flush_pend_reg <= 1'b0;
      seq_reg        <= '0;
      img_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      live_reg       <= 1'b1;
      flush_pend_reg <= flush || (flush_pend_reg && !pend_clr);
      if (accept) begin
        seq_reg       <= img_count_reg[11:0];
        img_count_reg <= img_count_reg + 32'd1;
      end
      if (beat_done)    fill_reg <= '0;
      else if (pack_we) fill_reg <= fill_reg + FILL_W'(1);
    end
  end

  // Record slots; cleared as a whole once a beat is handed off.
  for (genvar gi = 0; gi < MAX_SLOT; gi++) begin : g_slot
    if (gi < RES_PER_BEAT) begin : g_used
      sde_result_t slot_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     slot_reg <= '0;
        else if (beat_done)                             slot_reg <= '0;
        else if (pack_we && fill_reg == FILL_W'(gi))    slot_reg <= rec;
      end
      assign ots_data[gi*SDE_RES_W +: SDE_RES_W] = slot_reg;
      assign ots_keep[gi*4 +: 4] = (fill_reg > FILL_W'(gi)) ? 4'hF : 4'h0;
    end else begin : g_unused
      assign ots_data[gi*SDE_RES_W +: SDE_RES_W] = '0;
      assign ots_keep[gi*4 +: 4] = 4'h0;
    end
  end

`ifdef CL_SDE_ARGMAX_TIMEOUT_EN
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_reg;

  assign timeout_hit = (idle_cnt_reg == CNT_W'(FLUSH_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   idle_cnt_reg <= '0;
    else if (state_reg != ST_IDLE || accept || state_next != ST_IDLE) idle_cnt_reg <= '0;
    else if (fill_reg != '0 && !timeout_hit)                       idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
